// File: rtl/ball_control.sv
// Frame-rate controller for the ball's horizontal motion: per-frame event capture,
// direction/speed decisions, scoring and the serve/play/point/over sequence.
module ball_control #(
  parameter int unsigned p_START_SPEED      = 1,
  parameter int unsigned p_MAX_SPEED        = 5,
  parameter int unsigned p_HITS_PER_SPEEDUP = 4,
  parameter int unsigned p_SERVE_FRAMES     = 60,
  parameter int unsigned p_POINT_FRAMES     = 90,
  parameter int unsigned p_WIN_SCORE        = 9
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_HReset,
  input  logic       i_VReset,
  input  logic       i_HBlank,
  input  logic       i_VBlank,
  input  logic       i_Ball_Video,
  input  logic       i_Paddle_L_Video,
  input  logic       i_Paddle_R_Video,
  input  logic       i_Start,
  output logic       o_HDir,
  output logic [2:0] o_Speed,
  output logic       o_Ball_Enable,
  output logic [3:0] o_Score_L,
  output logic [3:0] o_Score_R,
  output logic       o_Game_Over
);

  localparam int unsigned FRAME_MAX = (p_SERVE_FRAMES > p_POINT_FRAMES) ? p_SERVE_FRAMES
                                                                        : p_POINT_FRAMES;
  localparam int unsigned CW = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1;

  localparam logic [CW-1:0] SERVE_LAST = CW'(p_SERVE_FRAMES - 1);
  localparam logic [CW-1:0] POINT_LAST = CW'(p_POINT_FRAMES - 1);
  localparam logic [2:0]    START_SPD  = 3'(p_START_SPEED);
  localparam logic [2:0]    MAX_SPD    = 3'(p_MAX_SPEED);
  localparam logic [3:0]    HITS_LAST  = 4'(p_HITS_PER_SPEEDUP - 1);
  localparam logic [3:0]    WIN        = 4'(p_WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_POINT,
    S_OVER
  } state_t;

  state_t        state_q;
  logic          hdir_q, en_q, over_q;
  logic [2:0]    speed_q;
  logic [3:0]    score_l_q, score_r_q, hit_cnt_q;
  logic [CW-1:0] frame_cnt_q;
  logic          hit_l_q, hit_r_q, edge_l_q, edge_r_q;
  logic          hblank_q, ball_q;

  logic          ft;
  logic          reversal_d;
  logic [2:0]    speed_up_d;
  logic [3:0]    score_l_d, score_r_d;

  assign ft = i_VReset && i_HReset;

  always_comb begin
    // Only a hit on the paddle the ball is travelling toward counts as a reversal.
    reversal_d = (hit_l_q && !hdir_q) || (hit_r_q && hdir_q);
    speed_up_d = (speed_q >= MAX_SPD) ? MAX_SPD : speed_q + 3'd1;
    score_l_d  = (score_l_q == 4'hF) ? 4'hF : score_l_q + 4'd1;
    score_r_d  = (score_r_q == 4'hF) ? 4'hF : score_r_q + 4'd1;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q     <= S_IDLE;
      hdir_q      <= 1'b1;
      speed_q     <= '0;
      en_q        <= 1'b0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      over_q      <= 1'b0;
      hit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      hit_l_q     <= 1'b0;
      hit_r_q     <= 1'b0;
      edge_l_q    <= 1'b0;
      edge_r_q    <= 1'b0;
      hblank_q    <= 1'b0;
      ball_q      <= 1'b0;
    end else begin
      hblank_q <= i_HBlank;
      ball_q   <= i_Ball_Video;
      if (ft) begin
        hit_l_q  <= 1'b0;
        hit_r_q  <= 1'b0;
        edge_l_q <= 1'b0;
        edge_r_q <= 1'b0;
        case (state_q)
          S_IDLE, S_OVER: begin
            if (i_Start) begin
              score_l_q   <= '0;
              score_r_q   <= '0;
              hdir_q      <= 1'b1;
              speed_q     <= '0;
              en_q        <= 1'b1;
              over_q      <= 1'b0;
              frame_cnt_q <= '0;
              state_q     <= S_SERVE;
            end
          end
          S_SERVE: begin
            if (frame_cnt_q == SERVE_LAST) begin
              speed_q     <= START_SPD;
              hit_cnt_q   <= '0;
              frame_cnt_q <= '0;
              state_q     <= S_PLAY;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
          S_PLAY: begin
            if (reversal_d) begin
              hdir_q <= !hdir_q;
              if (hit_cnt_q == HITS_LAST) begin
                hit_cnt_q <= '0;
                speed_q   <= speed_up_d;
              end else begin
                hit_cnt_q <= hit_cnt_q + 4'd1;
              end
            end else if (edge_l_q || edge_r_q) begin
              // Serve goes toward the player who lost the point.
              speed_q     <= '0;
              en_q        <= 1'b0;
              hdir_q      <= !edge_l_q;
              frame_cnt_q <= '0;
              if (edge_l_q) begin
                score_r_q <= score_r_d;
                if (score_r_d == WIN) begin
                  over_q  <= 1'b1;
                  state_q <= S_OVER;
                end else begin
                  state_q <= S_POINT;
                end
              end else begin
                score_l_q <= score_l_d;
                if (score_l_d == WIN) begin
                  over_q  <= 1'b1;
                  state_q <= S_OVER;
                end else begin
                  state_q <= S_POINT;
                end
              end
            end
          end
          S_POINT: begin
            if (frame_cnt_q == POINT_LAST) begin
              en_q        <= 1'b1;
              frame_cnt_q <= '0;
              state_q     <= S_SERVE;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (!i_VBlank) begin
        if (i_Ball_Video && i_Paddle_L_Video) hit_l_q <= 1'b1;
        if (i_Ball_Video && i_Paddle_R_Video) hit_r_q <= 1'b1;
        if (hblank_q && !i_HBlank && i_Ball_Video) edge_l_q <= 1'b1;
        if (!hblank_q && i_HBlank && ball_q) edge_r_q <= 1'b1;
      end
    end
  end

  assign o_HDir        = hdir_q;
  assign o_Speed       = speed_q;
  assign o_Ball_Enable = en_q;
  assign o_Score_L     = score_l_q;
  assign o_Score_R     = score_r_q;
  assign o_Game_Over   = over_q;

endmodule

// File: tb/tb_ball_control.sv
// Scoreboard bench for ball_control: short synthetic frames, expectations queued per frame tick.
module tb_ball_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, hreset, vreset, hblank, vblank, ball, padl, padr, start;
  logic       hdir, en, go;
  logic [2:0] speed;
  logic [3:0] sl, sr;

  ball_control dut (
    .i_Clk            (clk),
    .i_Rst_n          (rst_n),
    .i_HReset         (hreset),
    .i_VReset         (vreset),
    .i_HBlank         (hblank),
    .i_VBlank         (vblank),
    .i_Ball_Video     (ball),
    .i_Paddle_L_Video (padl),
    .i_Paddle_R_Video (padr),
    .i_Start          (start),
    .o_HDir           (hdir),
    .o_Speed          (speed),
    .o_Ball_Enable    (en),
    .o_Score_L        (sl),
    .o_Score_R        (sr),
    .o_Game_Over      (go)
  );

  typedef struct packed {
    logic       chk;
    logic       hdir;
    logic [2:0] spd;
    logic       en;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       go;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    passed = 0;
  int    total  = 0;
  logic  force_obs = 1'b0;
  logic  obs_q = 1'b0;

  always @(posedge clk) obs_q = (vreset && hreset) || force_obs;

  always @(negedge clk) begin
    exp_t  e;
    exp_t  act;
    string nm;
    if (obs_q) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL underflow: output presented with no expectation queued");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.chk) begin
          total++;
          act = {1'b1, hdir, speed, en, sl, sr, go};
          if (act === e) passed++;
          else $display("FAIL %s: got hdir=%b spd=%0d en=%b sl=%0d sr=%0d go=%b, expected hdir=%b spd=%0d en=%b sl=%0d sr=%0d go=%b",
                        nm, hdir, speed, en, sl, sr, go, e.hdir, e.spd, e.en, e.sl, e.sr, e.go);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic h, input logic [2:0] s, input logic e,
                              input logic [3:0] l, input logic [3:0] r, input logic g);
    mk = {1'b1, h, s, e, l, r, g};
  endfunction

  task automatic cyc(input logic hb, vb, bv, pl, pr, f);
    hblank = hb; vblank = vb; ball = bv; padl = pl; padr = pr; hreset = f; vreset = f;
    @(negedge clk);
  endtask

  // One frame: a blanking pixel, a first-visible pixel (edgeL), a paddle-overlap pixel,
  // a last-visible pixel (edgeR on the following HBlank rise), then the frame tick.
  task automatic frame(input bit hl, hr, el, er, input bit chk, input string nm, input exp_t e);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, el, 0, 0, 0);
    cyc(0, 0, hl | hr, hl, hr, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, er, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    e.chk = chk;
    exp_q.push_back(e);
    name_q.push_back(nm);
    cyc(1, 1, 0, 0, 0, 1);
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) frame(0, 0, 0, 0, 0, "skip", '0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    hblank = 1'b0; vblank = 1'b0; ball = 1'b0; padl = 1'b0; padr = 1'b0;
    hreset = 1'b0; vreset = 1'b0;
    force_obs = 1'b1;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0)); name_q.push_back("reset");
    @(negedge clk);
    force_obs = 1'b0;
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);

    start = 1'b1;
    frame(0, 0, 0, 0, 1, "serve_entry", mk(1, 0, 1, 0, 0, 0));
    start = 1'b0;
    skip(58);
    frame(0, 0, 0, 0, 1, "serve_hold", mk(1, 0, 1, 0, 0, 0));
    frame(0, 0, 0, 0, 1, "serve_to_play", mk(1, 1, 1, 0, 0, 0));

    frame(0, 1, 0, 0, 1, "hitR_reverse", mk(0, 1, 1, 0, 0, 0));
    frame(0, 1, 0, 0, 1, "hitR_persist", mk(0, 1, 1, 0, 0, 0));
    frame(1, 0, 0, 0, 1, "hitL_reverse", mk(1, 1, 1, 0, 0, 0));
    frame(0, 1, 0, 0, 1, "hit3", mk(0, 1, 1, 0, 0, 0));
    frame(1, 0, 0, 0, 1, "speedup_4", mk(1, 2, 1, 0, 0, 0));
    for (int k = 5; k <= 20; k++) begin
      logic [2:0] s;
      s = ((1 + k / 4) > 5) ? 3'd5 : 3'(1 + k / 4);
      if (k % 2 == 1) frame(0, 1, 0, 0, 1, "hit_series", mk(0, s, 1, 0, 0, 0));
      else            frame(1, 0, 0, 0, 1, "hit_series", mk(1, s, 1, 0, 0, 0));
    end

    frame(0, 1, 0, 0, 1, "hitR_at_max", mk(0, 5, 1, 0, 0, 0));
    frame(1, 0, 1, 0, 1, "hit_beats_edge", mk(1, 5, 1, 0, 0, 0));
    frame(0, 1, 0, 0, 1, "hitR_again", mk(0, 5, 1, 0, 0, 0));
    frame(0, 0, 1, 0, 1, "edgeL_point", mk(0, 0, 0, 0, 1, 0));
    skip(88);
    frame(0, 0, 0, 0, 1, "point_hold", mk(0, 0, 0, 0, 1, 0));
    frame(0, 0, 0, 0, 1, "point_to_serve", mk(0, 0, 1, 0, 1, 0));
    skip(59);
    frame(0, 0, 0, 0, 1, "reserve_play", mk(0, 1, 1, 0, 1, 0));

    for (int i = 1; i <= 9; i++) begin
      frame(0, 0, 0, 1, 1, "edgeR_point", mk(1, 0, 0, 4'(i), 1, (i == 9)));
      if (i < 9) begin
        skip(149);
        frame(0, 0, 0, 0, 1, "replay", mk(1, 1, 1, 4'(i), 1, 0));
      end
    end

    frame(0, 0, 0, 0, 1, "over_hold", mk(1, 0, 0, 9, 1, 1));
    start = 1'b1;
    frame(0, 0, 0, 0, 1, "restart", mk(1, 0, 1, 0, 0, 0));
    start = 1'b0;
    skip(59);
    frame(0, 0, 0, 0, 1, "restart_play", mk(1, 1, 1, 0, 0, 0));
    frame(0, 1, 0, 0, 1, "restart_hitR", mk(0, 1, 1, 0, 0, 0));

    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    rst_n = 1'b0;
    force_obs = 1'b1;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0)); name_q.push_back("midplay_reset");
    cyc(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    force_obs = 1'b0;
    frame(0, 1, 0, 0, 1, "idle_after_reset", mk(1, 0, 0, 0, 0, 0));

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL queue_drained: got %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
